// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life engine: default grid size and FSM states.
package gol_pkg;

    // log2 of the grid side; the grid is 2^K x 2^K cells
    localparam int K_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SWAP = 2'd2
    } eng_state_t;

endpackage

// File: rtl/gol_engine_if.sv
// Control/display bus of the Game-of-Life engine.
// master = control block / display, slave = engine.
interface gol_engine_if
    import gol_pkg::*;
#(
    parameter int K = K_DEFAULT
) ();

    logic [K-1:0] wAddrR;
    logic [K-1:0] wAddrC;
    logic         write_en;
    logic         write_data;
    logic         change_state;
    logic [K-1:0] rAddrR;
    logic [K-1:0] rAddrC;
    logic         rData;
    logic         busy;
    logic         gen_done;
    logic [15:0]  gen_count;

    modport master (
        output wAddrR, wAddrC, write_en, write_data, change_state, rAddrR, rAddrC,
        input  rData, busy, gen_done, gen_count
    );

    modport slave (
        input  wAddrR, wAddrC, write_en, write_data, change_state, rAddrR, rAddrC,
        output rData, busy, gen_done, gen_count
    );

endinterface

// File: rtl/gol_row_next.sv
// Combinational B3/S23 next-row computation for one grid row.
// Bit c of a row vector is column c; columns wrap around the torus.
module gol_row_next
    import gol_pkg::*;
#(
    parameter int K = K_DEFAULT
) (
    input  logic [(1<<K)-1:0] up,
    input  logic [(1<<K)-1:0] mid,
    input  logic [(1<<K)-1:0] down,
    output logic [(1<<K)-1:0] nxt
);

    localparam int N = 1 << K;

    for (genvar c = 0; c < N; c++) begin : g_col
        localparam int CL = (c + N - 1) % N;
        localparam int CR = (c + 1) % N;

        // up to 8 neighbours, so the sum needs the full 4 bits
        logic [3:0] sum;

        assign sum = 4'(up[CL])   + 4'(up[c])   + 4'(up[CR])
                   + 4'(mid[CL])                + 4'(mid[CR])
                   + 4'(down[CL]) + 4'(down[c]) + 4'(down[CR]);

        assign nxt[c] = (sum == 4'd3) || (mid[c] && (sum == 4'd2));
    end

endmodule

// File: rtl/gol_engine.sv
// Game-of-Life engine: double-buffered toroidal grid, one row per cycle
// during CALC, bank flip in SWAP. Writes and generation requests are only
// accepted in IDLE; reads always come from the current bank.
module gol_engine
    import gol_pkg::*;
#(
    parameter int K = K_DEFAULT
) (
    input logic         clk,
    input logic         rst_b,
    gol_engine_if.slave bus
);

    localparam int           N   = 1 << K;
    localparam logic [K-1:0] ONE = K'(1);

    eng_state_t   state;
    eng_state_t   state_nx;
    logic         cur;
    logic [K-1:0] row;
    logic [N-1:0] bank [2][N];
    logic [15:0]  gen_count_q;
    logic         rdata_q;
    logic [N-1:0] row_up;
    logic [N-1:0] row_mid;
    logic [N-1:0] row_dn;
    logic [N-1:0] row_nx;

    // row-1 / row+1 wrap naturally in K-bit arithmetic
    assign row_up  = bank[cur][row - ONE];
    assign row_mid = bank[cur][row];
    assign row_dn  = bank[cur][row + ONE];

    gol_row_next #(.K(K)) u_row_next (
        .up   (row_up),
        .mid  (row_mid),
        .down (row_dn),
        .nxt  (row_nx)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.change_state) state_nx = CALC;
            CALC:    if (&row)             state_nx = SWAP;
            SWAP:                          state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    // grid banks, bank select, row counter, generation counter and read port
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int r = 0; r < N; r++) begin
                bank[0][r] <= '0;
                bank[1][r] <= '0;
            end
            cur         <= 1'b0;
            row         <= '0;
            gen_count_q <= '0;
            rdata_q     <= 1'b0;
        end else begin
            rdata_q <= bank[cur][bus.rAddrR][bus.rAddrC];
            case (state)
                IDLE: begin
                    if (bus.write_en) bank[cur][bus.wAddrR][bus.wAddrC] <= bus.write_data;
                    if (bus.change_state) row <= '0;
                end
                CALC: begin
                    bank[~cur][row] <= row_nx;
                    row             <= row + ONE;
                end
                SWAP: begin
                    cur         <= ~cur;
                    gen_count_q <= gen_count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rData     = rdata_q;
    assign bus.busy      = (state != IDLE);
    // suppressed while reset is held so an aborted SWAP never reports completion
    assign bus.gen_done  = (state == SWAP) && rst_b;
    assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_engine.sv
// Self-checking bench for gol_engine on an 8x8 grid: stimulus tasks push
// expected read data and gen_done timing into queues, a monitor pops and
// compares them; grid expectations come from a plain torus model.
module tb_gol_engine;

    localparam int K = 3;
    localparam int N = 1 << K;

    typedef struct {
        int r;
        int c;
        bit v;
    } rd_t;

    logic clk;
    logic rst_b;
    gol_engine_if #(.K(K)) bus ();

    gol_engine #(.K(K)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   rd_issue = 0;
    rd_t  rd_q[$];
    int   gen_q[$];
    bit   mdl    [N][N];
    bit   mdl_nx [N][N];
    int   exp_gc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: compares every read response and every gen_done pulse
    initial begin
        bit  pend;
        rd_t e;
        forever begin
            @(posedge clk);
            pend = rd_issue;
            #2;
            if (pend) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    check($sformatf("rData(%0d,%0d)", e.r, e.c), int'(bus.rData), int'(e.v));
                end
            end
            if (bus.gen_done) begin
                if (gen_q.size() == 0) check("gen_done_unexpected", 1, 0);
                else check("gen_done_cycle", cyc, gen_q.pop_front());
            end
        end
    end

    // model: one B3/S23 step on the torus
    task automatic model_step();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                int s = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            s += int'(mdl[(r + dr + N) % N][(c + dc + N) % N]);
                mdl_nx[r][c] = (s == 3) || (mdl[r][c] && s == 2);
            end
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mdl[r][c] = 1'b0;
        exp_gc = 0;
        gen_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        clear_model();
    endtask

    task automatic write_cell(input int r, input int c, input bit v);
        bus.wAddrR = K'(r); bus.wAddrC = K'(c); bus.write_data = v; bus.write_en = 1'b1;
        @(negedge clk);
        bus.write_en = 1'b0;
        mdl[r][c] = v;
    endtask

    task automatic read_cell(input int r, input int c, input bit v);
        rd_t e;
        bus.rAddrR = K'(r); bus.rAddrC = K'(c);
        rd_issue = 1'b1;
        e.r = r; e.c = c; e.v = v;
        rd_q.push_back(e);
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) read_cell(r, c, mdl[r][c]);
    endtask

    task automatic gen_start(input bit wr, input int r, input int c, input bit v);
        if (wr) begin
            bus.wAddrR = K'(r); bus.wAddrC = K'(c); bus.write_data = v; bus.write_en = 1'b1;
            mdl[r][c] = v;
        end
        bus.change_state = 1'b1;
        gen_q.push_back(cyc + N + 1);
        model_step();
        @(negedge clk);
        bus.change_state = 1'b0;
        bus.write_en = 1'b0;
        check("busy_calc", int'(bus.busy), 1);
    endtask

    task automatic gen_finish();
        for (int i = 0; i < 4 * N && bus.busy; i++) @(negedge clk);
        check("busy_timeout", int'(bus.busy), 0);
        check("gen_done_seen", gen_q.size(), 0);
        gen_q.delete();
        mdl = mdl_nx;
        exp_gc = (exp_gc + 1) & 16'hFFFF;
        check("gen_count", int'(bus.gen_count), exp_gc);
    endtask

    initial begin
        rst_b = 1'b0;
        bus.wAddrR = '0; bus.wAddrC = '0; bus.write_en = 1'b0; bus.write_data = 1'b0;
        bus.change_state = 1'b0; bus.rAddrR = '0; bus.rAddrC = '0;
        do_reset();

        // reset state
        check("rst_busy", int'(bus.busy), 0);
        check("rst_gen_done", int'(bus.gen_done), 0);
        check("rst_gen_count", int'(bus.gen_count), 0);
        read_all();

        // blinker, then a second generation with dropped traffic in CALC
        write_cell(3, 2, 1); write_cell(3, 3, 1); write_cell(3, 4, 1);
        gen_start(0, 0, 0, 0);
        gen_finish();
        read_all();
        gen_start(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        bus.wAddrR = '0; bus.wAddrC = '0; bus.write_data = 1'b1; bus.write_en = 1'b1;
        bus.change_state = 1'b1;
        read_cell(0, 0, mdl[0][0]);
        bus.write_en = 1'b0; bus.change_state = 1'b0;
        read_cell(3, 3, mdl[3][3]);
        gen_finish();
        repeat (N + 4) @(negedge clk);
        check("no_queued_gen", int'(bus.gen_count), exp_gc);
        read_all();

        // read latency
        do_reset();
        write_cell(5, 6, 1);
        read_cell(5, 6, 1'b1);
        read_cell(5, 7, 1'b0);
        read_cell(5, 6, 1'b1);

        // glider across the bottom-right corner, 4 generations
        do_reset();
        write_cell(5, 6, 1); write_cell(6, 7, 1);
        write_cell(7, 5, 1); write_cell(7, 6, 1); write_cell(7, 7, 1);
        repeat (4) begin
            gen_start(0, 0, 0, 0);
            gen_finish();
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                read_cell(r, c, (r == 6 && c == 7) || (r == 7 && c == 0) ||
                                (r == 0 && c == 6) || (r == 0 && c == 7) ||
                                (r == 0 && c == 0));

        // random soup with a write landing on the same edge as change_state
        do_reset();
        repeat (24) write_cell($urandom_range(0, N - 1), $urandom_range(0, N - 1),
                               $urandom_range(0, 2) != 0);
        repeat (3) begin
            gen_start(1, $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'b1);
            gen_finish();
            read_all();
        end

        // reset during CALC row 3
        gen_start(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_gen_count", int'(bus.gen_count), 0);
        check("midrst_gen_done", int'(bus.gen_done), 0);
        rst_b = 1'b1;
        clear_model();
        read_all();

        // gen_count wrap
        write_cell(2, 1, 1); write_cell(2, 2, 1); write_cell(2, 3, 1);
        force dut.gen_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.gen_count_q;
        @(negedge clk);
        check("gc_preload", int'(bus.gen_count), 16'hFFFF);
        exp_gc = 16'hFFFF;
        gen_start(0, 0, 0, 0);
        gen_finish();
        repeat (N + 4) @(negedge clk);
        check("gc_wrap_hold", int'(bus.gen_count), 0);
        read_all();

        repeat (3) @(negedge clk);
        check("rd_q_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gol_engine.md
GOL_ENGINE -- requirements
Module: gol_engine

Interface
REQ-001 Parameter: K, default 7, log2 of grid side; grid is N=2^K rows by N columns.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_b  input  1  reset, synchronous, active-low.
REQ-004 wAddrR  input  K  write row address from the control block.
REQ-005 wAddrC  input  K  write column address from the control block.
REQ-006 write_en  input  1  write strobe, one cell per cycle.
REQ-007 write_data  input  1  cell value to write; 1 = alive, 0 = dead.
REQ-008 change_state  input  1  single-cycle request to advance one generation.
REQ-009 rAddrR  input  K  display read row address.
REQ-010 rAddrC  input  K  display read column address.
REQ-011 rData  output  1  cell value at the read address, registered.
REQ-012 busy  output  1  high while a generation is being computed.
REQ-013 gen_done  output  1  one-cycle pulse when a new generation becomes current.
REQ-014 gen_count  output  16  number of completed generations, modulo 2^16.

Function
REQ-015 Storage: two N x N bit banks (A, B) and a bank-select bit cur; the current bank is the one selected by cur.
REQ-016 Writes: in IDLE with write_en=1, set current[wAddrR][wAddrC] to write_data at the clock edge.
REQ-017 Writes with write_en=1 outside IDLE are dropped and do not change either bank.
REQ-018 FSM states: IDLE, CALC, SWAP.
REQ-019 IDLE -> CALC when change_state=1; row counter is loaded with 0.
REQ-020 CALC: one row per cycle; next[row] is computed from current rows row-1, row, row+1 and written to the non-current bank; the row counter then increments.
REQ-021 CALC -> SWAP after row N-1 is written, i.e. after exactly N CALC cycles.
REQ-022 SWAP: toggle cur, increment gen_count (16-bit wrap to 0), assert gen_done for this cycle only, then -> IDLE.
REQ-023 Latency: a change_state accepted at edge t gives CALC for cycles t+1..t+N and SWAP at t+N+1; the new generation is readable from edge t+N+2.
REQ-024 busy = 1 exactly in CALC and SWAP.
REQ-025 change_state outside IDLE is ignored; there is no queuing.
REQ-026 Simultaneous write_en and change_state in IDLE: the write is applied, and the computation includes the written cell.
REQ-027 Rule B3/S23: a live cell with 2 or 3 live neighbours stays alive; a dead cell with exactly 3 live neighbours becomes alive; every other cell is dead.
REQ-028 Neighbourhood: the 8 surrounding cells, toroidal; row and column indices wrap modulo N (row -1 = N-1, column N = 0).
REQ-029 The neighbour sum is computed at 4-bit width; no truncation is permitted.
REQ-030 The current bank is never modified during CALC or SWAP.
REQ-031 rData is registered: the value of current[rAddrR][rAddrC] sampled at edge t appears after edge t, for 1-cycle latency.
REQ-032 rData reads the bank selected by cur at the sampling edge, including during CALC.

Reset
REQ-033 With rst_b=0 at a clock edge: both banks all-zero, cur=0, FSM=IDLE, row counter=0, rData=0, busy=0, gen_done=0, gen_count=0.
REQ-034 Reset asserted mid-CALC or in SWAP aborts the generation; gen_count does not increment and gen_done does not pulse.
REQ-035 Asynchronous behaviour on rst_b is prohibited.

Structure
REQ-036 Shared package gol_pkg: grid-size parameter default (K=7) and the engine state enum {IDLE, CALC, SWAP}.
REQ-037 Sub-module gol_row_next, purely combinational: inputs are three N-bit rows, output is the N-bit next row, with column wrap applied internally.
REQ-038 Bank select, row counter and FSM reside in gol_engine.

Verification
REQ-039 Blinker: K=3, write cells (3,2),(3,3),(3,4), pulse change_state -> gen_done at +N+1 = 9 cycles; cells (2,3),(3,3),(4,3) alive and all others dead; gen_count=1.
REQ-040 Wrap: K=3, glider at the bottom-right corner, 4 generations -> glider shifted (+1,+1) modulo 8, with cell count still 5.
REQ-041 Dropped traffic: write_en=1 with write_data=1 to (0,0) and a second change_state, both during CALC -> cell (0,0) unchanged and gen_count increments by exactly 1.
REQ-042 Reset mid-op: rst_b=0 at CALC row 3 -> next cycle busy=0, gen_count=0, every read returns 0.
REQ-043 Read latency: write (5,6)=1, then drive rAddr=(5,6) at edge t -> rData=1 after edge t; rAddr=(5,7) -> rData=0.
REQ-044 Counter wrap: force gen_count=16'hFFFF, run one generation -> gen_count=0 and gen_done pulses once.
